dmem_arbiter: RTL

Two-port round-robin arbiter and sequencer for the single-port word-addressed data memory in the RISC-V datapath. Port 0 is the core load/store unit and port 1 is the memory loader/debug port. The block grants one requester at a time and latches its command. It drives one registered read or write strobe per access and returns read data with a one-hot valid pulse. Requesters never touch the memory strobes directly.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arbiter_rr.sv | 23 ++
 rtl/dmem_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  localparam logic PORT_CORE   = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  function automatic logic [1:0] port_onehot(input logic idx);
    return (idx == PORT_LOADER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational 2-way round-robin picker; the last_grant register lives in the parent.
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       enable,
  output logic [1:0] grant
);

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (req[0] && (!req[1] || last_grant == PORT_LOADER)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port data memory
// shared by the load/store unit (port 0) and the loader/debug port (port 1).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  p0_req,
  input  logic                  p1_req,
  input  logic                  p0_we,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic [1:0]            gnt,
  output logic [1:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                  state, next_state;
  logic                    last_grant;
  logic                    winner;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [1:0]              pick;
  logic                    grant_any;
  logic                    pick_idx;
  logic                    sel_we;

  // Reset gates the picker so gnt falls with reset even while reqs are held.
  rr_arbiter2 u_arb (
    .req        ({p1_req, p0_req}),
    .last_grant (last_grant),
    .enable     (state == IDLE && !reset),
    .grant      (pick)
  );

  assign gnt       = pick;
  assign grant_any = |pick;
  assign pick_idx  = pick[1];
  assign sel_we    = pick_idx ? p1_we : p0_we;
  assign busy      = (state != IDLE);
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = ACCESS;
      ACCESS:  next_state = (cmd_we == ACC_WRITE) ? IDLE : RESPOND;
      RESPOND: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are launched from the grant so they are high only during ACCESS.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= PORT_LOADER;
      winner     <= PORT_CORE;
      cmd_we     <= ACC_READ;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
    end else begin
      mem_read  <= grant_any && (sel_we == ACC_READ);
      mem_write <= grant_any && (sel_we == ACC_WRITE);
      if (grant_any) begin
        last_grant <= pick_idx;
        winner     <= pick_idx;
        cmd_we     <= sel_we;
        cmd_addr   <= pick_idx ? p1_addr : p0_addr;
        cmd_wdata  <= pick_idx ? p1_wdata : p0_wdata;
      end
    end
  end

  // rdata is sticky; only rvalid pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 2'b00;
      rdata  <= '0;
    end else begin
      rvalid <= 2'b00;
      if (state == RESPOND) begin
        rvalid <= port_onehot(winner);
        rdata  <= mem_rdata;
      end
    end
  end

endmodule
